// File: rtl/rs_pkg.sv
// Shared types and tag helpers for the reservation-station slice.
// Tags are {valid, unit type[2:0], slot id}, sized by the caller's tag width.
package rs_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } op_e;

    localparam logic [2:0] UNIT_MEM = 3'b001;
    localparam logic [2:0] UNIT_ADD = 3'b010;
    localparam logic [2:0] UNIT_MUL = 3'b011;

    localparam int TAG_MAX_W = 32;

    function automatic logic [TAG_MAX_W-1:0] make_tag(input int tag_w, input logic [2:0] unit,
                                                      input logic [3:0] id);
        return (TAG_MAX_W'(1) << (tag_w - 1)) | (TAG_MAX_W'(unit) << (tag_w - 4)) | TAG_MAX_W'(id);
    endfunction

    // Both tags arrive zero-extended; only a broadcast with its valid MSB set can match.
    function automatic logic tag_match(input logic [TAG_MAX_W-1:0] a, input logic [TAG_MAX_W-1:0] b,
                                       input int tag_w);
        return ((a >> (tag_w - 1)) != '0) && (a == b);
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: older[i][j]=1 means slot i was allocated before slot j.
// Picks the single oldest requester as a one-hot vector.
module rs_age_matrix #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] alloc_vec,
    input  logic [NUM_ENTRIES-1:0] free_vec,
    input  logic [NUM_ENTRIES-1:0] req_vec,
    output logic [NUM_ENTRIES-1:0] oldest_vec
);

    logic [NUM_ENTRIES-1:0] older [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] blocked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    // A new slot is younger than everything already present.
                    if (alloc_vec[i])
                        older[i][j] <= 1'b0;
                    else if (alloc_vec[j])
                        older[i][j] <= 1'b1;
                    else if (free_vec[i] || free_vec[j])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        blocked    = '0;
        oldest_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i && req_vec[j] && older[j][i]) blocked[i] = 1'b1;
            end
            oldest_vec[i] = req_vec[i] & ~blocked[i];
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Multi-op integer ALU reservation station with CDB wake-up, dispatch bypass
// and oldest-first offload through a valid/ready handshake.
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int         NUM_ENTRIES = 8,
    parameter int         DATA_W      = 32,
    parameter int         TAG_W       = 8,
    parameter int         NUM_CDB     = 3,
    parameter int         LATENCY     = 4,
    parameter logic [2:0] UNIT_TYPE   = UNIT_ADD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      src_in_valid,
    input  logic [2:0]                op_in,
    input  logic [DATA_W-1:0]         src_in_1,
    input  logic [DATA_W-1:0]         src_in_2,
    input  logic                      src_in1_type,
    input  logic                      src_in2_type,
    input  logic [NUM_CDB*DATA_W-1:0] CDB_data_serialized,
    input  logic [NUM_CDB*TAG_W-1:0]  CDB_tag_serialized,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic [TAG_W-1:0]          reg_tag_out,
    output logic                      ready_for_instr,
    output logic [TAG_W-1:0]          acceptor_tag
);

    localparam int ID_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] busy, s1_rdy, s2_rdy, done_vec, oldest_vec, alloc_vec, free_vec;
    logic [2:0]             op_q   [NUM_ENTRIES];
    logic [DATA_W-1:0]      s1_q   [NUM_ENTRIES];
    logic [DATA_W-1:0]      s2_q   [NUM_ENTRIES];
    logic [2:0]             cntr   [NUM_ENTRIES];
    logic [DATA_W:0]        snoop1 [NUM_ENTRIES];
    logic [DATA_W:0]        snoop2 [NUM_ENTRIES];
    logic [DATA_W:0]        in1_snoop, in2_snoop;
    logic                   alloc_found, lock_vld, any_done, dispatch, offload;
    logic [ID_W-1:0]        alloc_id, sel_id, lock_id, oldest_id;

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c == 3'(LATENCY)) ? c : c + 3'd1;
    endfunction

    function automatic logic [DATA_W-1:0] alu(input logic [2:0] op, input logic signed [DATA_W-1:0] a,
                                             input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] r;
        case (op)
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    // Returns {hit, data}; scanning downwards lets the lowest channel index win.
    function automatic logic [DATA_W:0] cdb_snoop(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (tag_match(TAG_MAX_W'(CDB_tag_serialized[(NUM_CDB-1-c)*TAG_W +: TAG_W]),
                          TAG_MAX_W'(tag), TAG_W))
                r = {1'b1, CDB_data_serialized[(NUM_CDB-1-c)*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        alloc_found = 1'b0;
        alloc_id    = '0;
        oldest_id   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_found = 1'b1;
                alloc_id    = ID_W'(i);
            end
            if (oldest_vec[i]) oldest_id = ID_W'(i);
            done_vec[i] = busy[i] && (cntr[i] == 3'(LATENCY));
            snoop1[i]   = cdb_snoop(s1_q[i][TAG_W-1:0]);
            snoop2[i]   = cdb_snoop(s2_q[i][TAG_W-1:0]);
        end
        in1_snoop = cdb_snoop(src_in_1[TAG_W-1:0]);
        in2_snoop = cdb_snoop(src_in_2[TAG_W-1:0]);
    end

    rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
        .clk        (clk),
        .reset      (reset),
        .alloc_vec  (alloc_vec),
        .free_vec   (free_vec),
        .req_vec    (done_vec),
        .oldest_vec (oldest_vec)
    );

    // Once offered, a result stays pinned until granted even if an older slot finishes later.
    assign sel_id          = lock_vld ? lock_id : oldest_id;
    assign any_done        = |done_vec;
    assign data_out_valid  = en & any_done;
    assign data_out        = any_done ? alu(op_q[sel_id], s1_q[sel_id], s2_q[sel_id]) : '0;
    assign reg_tag_out     = any_done ? TAG_W'(make_tag(TAG_W, UNIT_TYPE, 4'(sel_id))) : '0;
    assign ready_for_instr = en & alloc_found;
    assign acceptor_tag    = alloc_found ? TAG_W'(make_tag(TAG_W, UNIT_TYPE, 4'(alloc_id))) : '0;
    assign dispatch        = src_in_valid & ready_for_instr & ~flush;
    assign offload         = data_out_valid & data_out_ready & ~flush;
    assign alloc_vec       = dispatch ? (NUM_ENTRIES'(1) << alloc_id) : '0;
    assign free_vec        = flush ? '1 : (offload ? (NUM_ENTRIES'(1) << sel_id) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            s1_rdy   <= '0;
            s2_rdy   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                op_q[i] <= '0;
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                cntr[i] <= '0;
            end
        end else if (flush) begin
            busy     <= '0;
            s1_rdy   <= '0;
            s2_rdy   <= '0;
            lock_vld <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) cntr[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (busy[i]) begin
                    if (!s1_rdy[i] && snoop1[i][DATA_W]) begin
                        s1_q[i]   <= snoop1[i][DATA_W-1:0];
                        s1_rdy[i] <= 1'b1;
                    end
                    if (!s2_rdy[i] && snoop2[i][DATA_W]) begin
                        s2_q[i]   <= snoop2[i][DATA_W-1:0];
                        s2_rdy[i] <= 1'b1;
                    end
                    if (s1_rdy[i] && s2_rdy[i]) cntr[i] <= sat_inc(cntr[i]);
                end
            end
            if (offload) begin
                busy[sel_id]   <= 1'b0;
                s1_rdy[sel_id] <= 1'b0;
                s2_rdy[sel_id] <= 1'b0;
                cntr[sel_id]   <= '0;
                lock_vld       <= 1'b0;
            end else if (data_out_valid) begin
                lock_vld <= 1'b1;
                lock_id  <= sel_id;
            end
            if (dispatch) begin
                busy[alloc_id]   <= 1'b1;
                op_q[alloc_id]   <= op_in;
                cntr[alloc_id]   <= '0;
                s1_q[alloc_id]   <= (src_in1_type && in1_snoop[DATA_W]) ? in1_snoop[DATA_W-1:0] : src_in_1;
                s2_q[alloc_id]   <= (src_in2_type && in2_snoop[DATA_W]) ? in2_snoop[DATA_W-1:0] : src_in_2;
                s1_rdy[alloc_id] <= !src_in1_type || in1_snoop[DATA_W];
                s2_rdy[alloc_id] <= !src_in2_type || in2_snoop[DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;

    logic        clk = 1'b0;
    logic        reset, en, flush, src_in_valid, src_in1_type, src_in2_type;
    logic [2:0]  op_in;
    logic [31:0] src_in_1, src_in_2;
    logic [95:0] cdb_data;
    logic [23:0] cdb_tag;
    logic        data_out_valid, data_out_ready, ready_for_instr;
    logic [31:0] data_out;
    logic [7:0]  reg_tag_out, acceptor_tag;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] fill_exp [8] = '{32'd22, 32'd2, 32'd8, 32'd14, 32'd6, 32'd22, 32'd22, 32'd22};

    alu_reservation_station dut (
        .clk                 (clk),
        .reset               (reset),
        .en                  (en),
        .flush               (flush),
        .src_in_valid        (src_in_valid),
        .op_in               (op_in),
        .src_in_1            (src_in_1),
        .src_in_2            (src_in_2),
        .src_in1_type        (src_in1_type),
        .src_in2_type        (src_in2_type),
        .CDB_data_serialized (cdb_data),
        .CDB_tag_serialized  (cdb_tag),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .data_out            (data_out),
        .reg_tag_out         (reg_tag_out),
        .ready_for_instr     (ready_for_instr),
        .acceptor_tag        (acceptor_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [31:0] a, input logic at,
                            input logic [31:0] b, input logic bt);
        op_in = op; src_in_1 = a; src_in1_type = at; src_in_2 = b; src_in2_type = bt;
        src_in_valid = 1'b1;
        step();
        src_in_valid = 1'b0;
    endtask

    task automatic grant();
        data_out_ready = 1'b1;
        step();
        data_out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; flush = 1'b0; src_in_valid = 1'b0; op_in = '0;
        src_in_1 = '0; src_in_2 = '0; src_in1_type = 1'b0; src_in2_type = 1'b0;
        cdb_data = '0; cdb_tag = '0; data_out_ready = 1'b0;
        #22 reset = 1'b1;
        #1;
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_tag", reg_tag_out, 0);
        chk("rst_ready", ready_for_instr, 1);
        chk("rst_acceptor", acceptor_tag, 8'hA0);

        // 1: ADD 5+7, both data
        dispatch(3'd0, 32'd5, 1'b0, 32'd7, 1'b0);
        chk("t1_acceptor", acceptor_tag, 8'hA1);
        repeat (3) step();
        chk("t1_early", data_out_valid, 0);
        step();
        chk("t1_valid", data_out_valid, 1);
        chk("t1_data", data_out, 32'd12);
        chk("t1_tag", reg_tag_out, 8'hA0);
        grant();
        chk("t1_freed", data_out_valid, 0);
        chk("t1_acc_back", acceptor_tag, 8'hA0);

        // 2: SUB with src1 woken by channel 2
        dispatch(3'd1, 32'hC3, 1'b1, 32'd30, 1'b0);
        chk("t2_wait", data_out_valid, 0);
        cdb_tag = {8'h00, 8'h00, 8'hC3}; cdb_data = {32'd0, 32'd0, 32'd100};
        step();
        cdb_tag = '0; cdb_data = '0;
        repeat (3) step();
        chk("t2_early", data_out_valid, 0);
        step();
        chk("t2_valid", data_out_valid, 1);
        chk("t2_data", data_out, 32'd70);
        grant();

        // 3: dispatch bypass; ch0 and ch2 both match, ch0 must win
        cdb_tag = {8'h91, 8'h00, 8'h91}; cdb_data = {32'd9, 32'd0, 32'd77};
        dispatch(3'd0, 32'h91, 1'b1, 32'd1, 1'b0);
        cdb_tag = '0; cdb_data = '0;
        repeat (3) step();
        chk("t3_early", data_out_valid, 0);
        step();
        chk("t3_valid", data_out_valid, 1);
        chk("t3_data", data_out, 32'd10);
        grant();

        // 4: fill all slots, op k on (12,10); ops 5..7 behave as ADD
        for (int k = 0; k < 8; k++) dispatch(3'(k), 32'd12, 1'b0, 32'd10, 1'b0);
        chk("t4_full_ready", ready_for_instr, 0);
        chk("t4_full_msb", acceptor_tag[7], 0);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", data_out_valid, 1);
            chk("t4_hold_data", data_out, 32'd22);
            chk("t4_hold_tag", reg_tag_out, 8'hA0);
            step();
        end
        en = 1'b0;
        #1;
        chk("t4_stall_valid", data_out_valid, 0);
        step();
        en = 1'b1;
        #1;
        chk("t4_stall_hold", data_out, 32'd22);
        for (int k = 0; k < 8; k++) begin
            chk("t4_drain_data", data_out, fill_exp[k]);
            chk("t4_drain_tag", reg_tag_out, 8'hA0 + 8'(k));
            grant();
            if (k == 0) chk("t4_acc_after_free", acceptor_tag, 8'hA0);
        end
        chk("t4_empty", data_out_valid, 0);

        // 5: A lands in slot 3, B in slot 1, both woken together; A is older
        dispatch(3'd0, 32'h80, 1'b1, 32'd0, 1'b0);
        dispatch(3'd0, 32'd20, 1'b0, 32'd5, 1'b0);
        dispatch(3'd0, 32'h82, 1'b1, 32'd0, 1'b0);
        dispatch(3'd0, 32'hE5, 1'b1, 32'd1, 1'b0);
        chk("t5_a_slot", acceptor_tag, 8'hA4);
        step();
        step();
        chk("t5_s1_data", data_out, 32'd25);
        chk("t5_s1_tag", reg_tag_out, 8'hA1);
        grant();
        chk("t5_s1_freed", acceptor_tag, 8'hA1);
        dispatch(3'd4, 32'hE5, 1'b1, 32'd3, 1'b0);
        cdb_tag = {8'h00, 8'hE5, 8'h00}; cdb_data = {32'd0, 32'd50, 32'd0};
        step();
        cdb_tag = '0; cdb_data = '0;
        repeat (3) step();
        chk("t5_early", data_out_valid, 0);
        step();
        chk("t5_first_tag", reg_tag_out, 8'hA3);
        chk("t5_first_data", data_out, 32'd51);
        grant();
        chk("t5_second_tag", reg_tag_out, 8'hA1);
        chk("t5_second_data", data_out, 32'd49);
        grant();
        chk("t5_done", data_out_valid, 0);

        // 6: flush with slots 0..2 busy plus a same-cycle dispatch
        dispatch(3'd0, 32'h81, 1'b1, 32'd0, 1'b0);
        chk("t6_busy3", acceptor_tag, 8'hA3);
        flush = 1'b1;
        dispatch(3'd0, 32'd1, 1'b0, 32'd1, 1'b0);
        flush = 1'b0;
        chk("t6_flush_acc", acceptor_tag, 8'hA0);
        chk("t6_flush_ready", ready_for_instr, 1);
        cdb_tag = {8'h80, 8'h81, 8'h82}; cdb_data = {32'd1, 32'd2, 32'd3};
        step();
        cdb_tag = '0; cdb_data = '0;
        repeat (6) step();
        chk("t6_no_stale", data_out_valid, 0);
        chk("t6_data0", data_out, 0);

        // async reset in the middle of execution
        dispatch(3'd0, 32'd2, 1'b0, 32'd3, 1'b0);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", data_out_valid, 0);
        chk("t6_rst_acc", acceptor_tag, 8'hA0);
        #4 reset = 1'b1;
        repeat (6) step();
        chk("t6_post_valid", data_out_valid, 0);
        chk("t6_post_data", data_out, 0);
        chk("t6_post_tag", reg_tag_out, 0);
        chk("t6_post_ready", ready_for_instr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
